// File: rtl/alu_pkg.sv
// Shared types for the N-bit ALU: opcode encoding, sequencer states, flag bundle.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b0001,
      OP_XOR  = 4'b0010,
      OP_SLT  = 4'b0011,
      OP_AND  = 4'b0100,
      OP_NAND = 4'b0101,
      OP_NOR  = 4'b0110,
      OP_OR   = 4'b0111,
      OP_MUL  = 4'b1000
   } op_e;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_MUL_BUSY = 1'b1
   } state_e;

   typedef struct packed {
      logic carry;
      logic overflow;
      logic zero;
      logic negative;
      logic err;
   } flags_t;

   localparam flags_t FLAGS_CLR = '0;

   // Subtract-style ops run the adder as a + ~b + 1.
   function automatic logic op_is_sub(input logic [3:0] op);
      return (op == OP_SUB) || (op == OP_SLT);
   endfunction

endpackage

// File: rtl/alu_slice.sv
// One bit of the ALU datapath: b-inversion, full adder, logic functions, op mux.
module alu_slice
   import alu_pkg::*;
(
   input  logic [3:0] i_op,
   input  logic       i_a,
   input  logic       i_b,
   input  logic       i_cin,
   output logic       o_sum,
   output logic       o_cout,
   output logic       o_res
);

   logic w_b_eff;
   logic w_p;

   assign w_b_eff = i_b ^ op_is_sub(i_op);
   assign w_p     = i_a ^ w_b_eff;
   assign o_sum   = w_p ^ i_cin;
   assign o_cout  = (i_a & w_b_eff) | (w_p & i_cin);

   // Per-bit result select; SLT and MUL are assembled at the top level.
   always_comb begin
      o_res = 1'b0;
      case (i_op)
         OP_ADD, OP_SUB: o_res = o_sum;
         OP_XOR:         o_res = i_a ^ i_b;
         OP_AND:         o_res = i_a & i_b;
         OP_NAND:        o_res = ~(i_a & i_b);
         OP_NOR:         o_res = ~(i_a | i_b);
         OP_OR:          o_res = i_a | i_b;
         default:        o_res = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_nbit.sv
// N-bit ALU: ripple-carry slice array for single-cycle ops, shift-add multiplier
// sequencer, valid/ready handshake and registered result/flags.
module alu_nbit
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             negative,
   output logic             err
);

   localparam int                CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

   state_e             r_state, w_state_nxt;
   logic               r_out_valid;
   logic [WIDTH-1:0]   r_result;
   flags_t             r_flags;
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [CNT_W-1:0]   r_cnt;

   logic [WIDTH:0]     w_c;
   logic [WIDTH-1:0]   w_sum;
   logic [WIDTH-1:0]   w_logic;
   logic               w_ovf;
   logic               w_lt;
   logic [WIDTH-1:0]   w_sc_res;
   flags_t             w_sc_flags;
   logic [2*WIDTH-1:0] w_acc_nxt;
   flags_t             w_mul_flags;
   logic               w_slot_free;
   logic               w_accept;
   logic               w_is_mul;
   logic               w_mul_last;
   logic               w_mul_done;

   // Carry-in: ADD uses c_in, subtract-style ops force +1, others don't care.
   always_comb begin
      w_c[0] = 1'b0;
      if (op == OP_ADD)     w_c[0] = c_in;
      else if (op_is_sub(op)) w_c[0] = 1'b1;
   end

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
      alu_slice u_slice (
         .i_op   (op),
         .i_a    (a[gi]),
         .i_b    (b[gi]),
         .i_cin  (w_c[gi]),
         .o_sum  (w_sum[gi]),
         .o_cout (w_c[gi+1]),
         .o_res  (w_logic[gi])
      );
   end

   assign w_ovf = w_c[WIDTH] ^ w_c[WIDTH-1];
   // Signed less-than from the a-b subtraction: sign corrected by overflow.
   assign w_lt  = w_sum[WIDTH-1] ^ w_ovf;

   // Single-cycle result and flags; illegal opcodes report err with everything else clear.
   always_comb begin
      w_sc_res   = '0;
      w_sc_flags = FLAGS_CLR;
      case (op)
         OP_ADD, OP_SUB: begin
            w_sc_res            = w_sum;
            w_sc_flags.carry    = w_c[WIDTH];
            w_sc_flags.overflow = w_ovf;
         end
         OP_SLT:                                w_sc_res = {{(WIDTH-1){1'b0}}, w_lt};
         OP_XOR, OP_AND, OP_NAND, OP_NOR, OP_OR: w_sc_res = w_logic;
         OP_MUL:                                w_sc_res = '0;
         default:                               w_sc_flags.err = 1'b1;
      endcase
      if (!w_sc_flags.err) begin
         w_sc_flags.zero     = (w_sc_res == '0);
         w_sc_flags.negative = w_sc_res[WIDTH-1];
      end
   end

   // Multiplier: add current partial product; the last one folds into the final load.
   assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

   always_comb begin
      w_mul_flags          = FLAGS_CLR;
      w_mul_flags.carry    = |w_acc_nxt[2*WIDTH-1:WIDTH];
      w_mul_flags.zero     = (w_acc_nxt[WIDTH-1:0] == '0);
      w_mul_flags.negative = w_acc_nxt[WIDTH-1];
   end

   assign w_slot_free = !r_out_valid || out_ready;
   assign in_ready    = (r_state == ST_IDLE) && w_slot_free;
   assign w_accept    = in_valid && in_ready;
   assign w_is_mul    = (op == OP_MUL);
   assign w_mul_last  = (r_state == ST_MUL_BUSY) && (r_cnt == CNT_LAST);
   // Final load waits for a free output slot; until then the sequencer is frozen.
   assign w_mul_done  = w_mul_last && w_slot_free;

   // Next-state logic for the multiply sequencer.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:     if (w_accept && w_is_mul) w_state_nxt = ST_MUL_BUSY;
         ST_MUL_BUSY: if (w_mul_done)           w_state_nxt = ST_IDLE;
         default:                               w_state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Multiplier operand/accumulator registers, one partial product per busy cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
      end else if (w_accept && w_is_mul) begin
         r_acc    <= '0;
         r_mcand  <= {{WIDTH{1'b0}}, a};
         r_mplier <= b;
         r_cnt    <= '0;
      end else if ((r_state == ST_MUL_BUSY) && !w_mul_last) begin
         r_acc    <= w_acc_nxt;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + CNT_W'(1);
      end else if (w_mul_done) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
      end
   end

   // Output register: load on single-cycle accept or multiply completion, drop on consume.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_flags     <= FLAGS_CLR;
      end else if (w_accept && !w_is_mul) begin
         r_out_valid <= 1'b1;
         r_result    <= w_sc_res;
         r_flags     <= w_sc_flags;
      end else if (w_mul_done) begin
         r_out_valid <= 1'b1;
         r_result    <= w_acc_nxt[WIDTH-1:0];
         r_flags     <= w_mul_flags;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign carry     = r_flags.carry;
   assign overflow  = r_flags.overflow;
   assign zero      = r_flags.zero;
   assign negative  = r_flags.negative;
   assign err       = r_flags.err;

endmodule

// File: tb/tb_alu_nbit.sv
// Directed bench for alu_nbit (WIDTH=8) with an in-order scoreboard.
module tb_alu_nbit;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, c_in, out_valid, out_ready;
   logic         carry, overflow, zero, negative, err;
   logic [3:0]   op;
   logic [W-1:0] a, b, result;

   typedef struct packed {
      logic [W-1:0] res;
      logic [4:0]   fl;   // {carry, overflow, zero, negative, err}
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errs   = 0;

   always #5 clk = ~clk;

   alu_nbit #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .c_in(c_in), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .carry(carry),
      .overflow(overflow), .zero(zero), .negative(negative), .err(err)
   );

   function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x,
                                  input logic [W-1:0] y, input logic ci);
      exp_t         e;
      logic [W:0]   s;
      logic [2*W-1:0] p;
      logic         c, v;
      e = '0; c = 1'b0; v = 1'b0;
      case (o)
         4'd0: begin
            s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
            e.res = s[W-1:0]; c = s[W];
            v = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
         end
         4'd1: begin
            s = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
            e.res = s[W-1:0]; c = s[W];
            v = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
         end
         4'd2: e.res = x ^ y;
         4'd3: e.res = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
         4'd4: e.res = x & y;
         4'd5: e.res = ~(x & y);
         4'd6: e.res = ~(x | y);
         4'd7: e.res = x | y;
         4'd8: begin
            p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
            e.res = p[W-1:0]; c = |p[2*W-1:W];
         end
         default: begin
            e.fl = 5'b00001;
            return e;
         end
      endcase
      e.fl = {c, v, (e.res == '0), e.res[W-1], 1'b0};
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errs++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock cycle: score a consumed result, record an accepted op, advance.
   task automatic cyc();
      exp_t e;
      #1;
      if (out_valid && out_ready) begin
         n_checks++;
         assert (q.size() > 0) else begin
            n_errs++;
            $error("FAIL sb_empty: observed result=%0h expected no output", result);
         end
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("sb_res", 64'(result), 64'(e.res));
            chk("sb_flags", 64'({carry, overflow, zero, negative, err}), 64'(e.fl));
         end
      end
      if (in_valid && in_ready) q.push_back(model(op, a, b, c_in));
      @(negedge clk);
   endtask

   task automatic issue(input logic [3:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic ci);
      in_valid = 1'b1; op = o; a = x; b = y; c_in = ci;
      cyc();
      in_valid = 1'b0; op = 4'($urandom); a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
   endtask

   // Counts cycles from acceptance until out_valid, checking the block stays busy.
   task automatic wait_out(output int lat);
      lat = 1;
      while (!out_valid && lat < 20) begin
         chk("mul_busy_rdy", 64'(in_ready), 64'd0);
         cyc();
         lat++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int         lat;
      logic [3:0] ops [5] = '{4'd2, 4'd4, 4'd5, 4'd6, 4'd7};

      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      op = '0; a = '0; b = '0; c_in = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_flags", 64'({carry, overflow, zero, negative, err}), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1 chk("rst_rdy", 64'(in_ready), 64'd1);
      @(negedge clk);

      // ADD with signed overflow
      issue(4'd0, 8'h7F, 8'h01, 1'b0);
      chk("add_valid", 64'(out_valid), 64'd1);
      chk("add_res", 64'(result), 64'h80);
      chk("add_flags", 64'({carry, overflow, zero, negative, err}), 64'b01010);
      cyc();

      // SUB with borrow
      issue(4'd1, 8'h00, 8'h01, 1'b1);
      chk("sub_res", 64'(result), 64'hFF);
      chk("sub_flags", 64'({carry, overflow, zero, negative, err}), 64'b00010);
      cyc();

      // SLT signed
      issue(4'd3, 8'hFF, 8'h01, 1'b0);
      chk("slt_res", 64'(result), 64'h01);
      cyc();

      // Logic ops back-to-back, full throughput
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; op = ops[i]; a = 8'hA5 + 8'(i); b = 8'h3C ^ 8'(i * 3); c_in = 1'b0;
         chk("tput_rdy", 64'(in_ready), 64'd1);
         cyc();
      end
      in_valid = 1'b0;
      cyc();

      // MUL without high bits
      issue(4'd8, 8'h0F, 8'h11, 1'b0);
      wait_out(lat);
      chk("mul1_lat", 64'(lat), 64'd9);
      chk("mul1_res", 64'(result), 64'hFF);
      chk("mul1_carry", 64'(carry), 64'd0);
      cyc();

      // MUL with discarded high bits
      issue(4'd8, 8'h10, 8'h10, 1'b0);
      wait_out(lat);
      chk("mul2_lat", 64'(lat), 64'd9);
      chk("mul2_flags", 64'({carry, overflow, zero, negative, err}), 64'b10100);
      cyc();

      // Backpressure: held result, second op accepted the cycle the slot frees
      out_ready = 1'b0;
      issue(4'd0, 8'h01, 8'h02, 1'b0);
      in_valid = 1'b1; op = 4'd0; a = 8'h03; b = 8'h04; c_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("bp_rdy", 64'(in_ready), 64'd0);
         chk("bp_hold", 64'({out_valid, result}), 64'h103);
         chk("bp_flags", 64'({carry, overflow, zero, negative, err}), 64'd0);
         cyc();
      end
      out_ready = 1'b1;
      #1 chk("bp_release_rdy", 64'(in_ready), 64'd1);
      cyc();
      in_valid = 1'b0;
      chk("bp_second", 64'({out_valid, result}), 64'h107);
      cyc();
      chk("bp_drained", 64'(q.size()), 64'd0);

      // Illegal opcode
      issue(4'b1010, 8'h12, 8'h34, 1'b0);
      chk("ill_valid", 64'(out_valid), 64'd1);
      chk("ill_res", 64'(result), 64'd0);
      chk("ill_flags", 64'({carry, overflow, zero, negative, err}), 64'b00001);
      cyc();

      // Reset in the middle of a multiply
      issue(4'd8, 8'h03, 8'h05, 1'b0);
      repeat (2) cyc();
      #1 rst_n = 1'b0;
      q.delete();
      #1 chk("mrst_valid", 64'(out_valid), 64'd0);
      cyc();
      rst_n = 1'b1;
      #1 chk("mrst_rdy", 64'(in_ready), 64'd1);
      for (int k = 0; k < 12; k++) begin
         chk("mrst_quiet", 64'(out_valid), 64'd0);
         cyc();
      end
      issue(4'd0, 8'h05, 8'h0A, 1'b1);
      chk("post_rst_add", 64'(result), 64'h10);
      cyc();
      chk("sb_final", 64'(q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_nbit.md
ALU_NBIT -- requirements
Module: alu_nbit

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits (legal range 2..64).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand/opcode presented this cycle.
REQ-005 in_ready  output  1  block accepts operation this cycle.
REQ-006 op  input  4  opcode (alu_pkg encoding).
REQ-007 a, b  input  WIDTH each  operands.
REQ-008 c_in  input  1  carry-in, used by ADD/SUB only.
REQ-009 out_valid  output  1  result register holds unconsumed result.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 result  output  WIDTH  operation result.
REQ-012 carry, overflow, zero, negative, err  output  1 each  result flags.

Function
REQ-013 Opcodes SHALL be: 0000 ADD, 0001 SUB, 0010 XOR, 0011 SLT, 0100 AND, 0101 NAND, 0110 NOR, 0111 OR, 1000 MUL; 1001-1111 illegal.
REQ-014 ADD SHALL compute a+b+c_in; SUB SHALL compute a+~b+1 (c_in ignored); carry = adder carry-out (SUB: 1 = no borrow).
REQ-015 overflow SHALL be signed two's-complement overflow for ADD/SUB; 0 for all other ops.
REQ-016 SLT SHALL return 1 when signed a < signed b, else 0, carry=0.
REQ-017 Logic ops SHALL be bitwise over WIDTH bits, carry=0, overflow=0.
REQ-018 MUL SHALL return the low WIDTH bits of unsigned a*b via shift-add, one partial product per cycle; carry=1 if any discarded high product bit is nonzero.
REQ-019 zero SHALL be 1 iff result==0; negative SHALL equal result[WIDTH-1], for every op.
REQ-020 Illegal opcode SHALL produce result=0, err=1, other flags 0, latency 1; err=0 for legal ops.
REQ-021 Handshake: operation accepted iff in_valid && in_ready on a rising edge; result consumed iff out_valid && out_ready.
REQ-022 FSM states IDLE, MUL_BUSY. in_ready SHALL be 1 iff state==IDLE and (out_valid==0 or out_ready==1).
REQ-023 Single-cycle ops: result and flags SHALL load into output register on acceptance edge; out_valid=1 the following cycle (latency 1).
REQ-024 MUL: acceptance SHALL latch a, b, clear accumulator, enter MUL_BUSY; after exactly WIDTH cycles in MUL_BUSY, result SHALL load and state return to IDLE; out_valid rises WIDTH+1 cycles after acceptance.
REQ-025 MUL SHALL not enter final load while out_valid=1 and out_ready=0; state holds in MUL_BUSY with accumulator frozen until output slot frees.
REQ-026 Simultaneous consume and accept SHALL sustain one op per cycle throughput for single-cycle ops with no bubble.
REQ-027 out_valid=1 with out_ready=0 SHALL hold result and flags stable.
REQ-028 Operands SHALL be sampled only at acceptance; changes to a, b, op afterward have no effect.

Reset
REQ-029 rst_n low SHALL immediately force state=IDLE, out_valid=0, result=0, all flags 0, accumulator and counter 0.
REQ-030 Reset asserted mid-MUL SHALL abandon the operation; no result emitted after release.
REQ-031 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-032 Opcode enum, FSM state enum and flag-bundle typedef SHALL live in shared package alu_pkg.
REQ-033 Per-bit datapath SHALL be sub-module alu_slice (invert controls, full adder, logic outputs, op mux), instantiated WIDTH times with ripple carry.
REQ-034 MUL sequencer, handshake and output register SHALL be in alu_nbit top level.

Verification (WIDTH=8)
REQ-035 ADD a=0x7F b=0x01 c_in=0 -> result 0x80, overflow=1, negative=1, carry=0, zero=0, out_valid next cycle.
REQ-036 SUB a=0x00 b=0x01 -> result 0xFF, carry=0, overflow=0, negative=1; SLT a=0xFF b=0x01 -> result 0x01.
REQ-037 MUL a=0x0F b=0x11 -> result 0xFF, carry=0, out_valid 9 cycles after acceptance, in_ready=0 throughout; MUL 0x10*0x10 -> 0x00, carry=1, zero=1.
REQ-038 out_ready=0, two back-to-back ADDs -> first held stable, in_ready=0, second accepted in same cycle out_ready rises; no loss or duplication.
REQ-039 rst_n pulsed low 3 cycles into MUL -> out_valid stays 0, in_ready=1 first cycle after release, next ADD correct.
REQ-040 op=1010 -> result 0x00, err=1, latency 1.
